// File: rtl/irq_controller.sv
// Multi-source IRQ controller: edge-detects and latches external requests,
// applies a software mask and the CPSR I-bit, picks the lowest enabled index,
// and runs the INT_irq/INTA_irq handshake with decode. Interrupts never nest:
// a new request is only raised once the handler signals IRQ_done.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   EX_irq        external level requests; a rising edge latches pending
//   CPSR_7        CPSR I-bit, 1 = IRQ disabled
//   INTA_irq      one-cycle acknowledge from decode (honoured only in REQ)
//   IRQ_done      one-cycle handler-return pulse (honoured only in SERVICE)
//   mask_we       mask write strobe
//   mask_wdata    new mask, bit=1 enables the source
//   INT_irq       registered interrupt request to decode
//   irq_id        source being requested or serviced
//   irq_vector    VEC_BASE + 4*irq_id
//   in_service    handler active
//   pending       latched request bits
//   mask          current mask
module irq_controller #(
    parameter int unsigned   N_SRC    = 8,
    parameter logic [31:0]   VEC_BASE = 32'h0000_0018,
    localparam int unsigned  ID_W     = $clog2(N_SRC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  EX_irq,
    input  logic              CPSR_7,
    input  logic              INTA_irq,
    input  logic              IRQ_done,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_wdata,
    output logic              INT_irq,
    output logic [ID_W-1:0]   irq_id,
    output logic [31:0]       irq_vector,
    output logic              in_service,
    output logic [N_SRC-1:0]  pending,
    output logic [N_SRC-1:0]  mask
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [N_SRC-1:0]    prev_q, prev_d;
    logic [N_SRC-1:0]    pending_q, pending_d;
    logic [N_SRC-1:0]    mask_q, mask_d;
    logic [ID_W-1:0]     irq_id_q, irq_id_d;
    logic                int_irq_q, int_irq_d;
    logic                in_service_q, in_service_d;

    logic [N_SRC-1:0]    rise;
    logic [N_SRC-1:0]    active;
    logic [N_SRC-1:0]    pending_clr;
    logic [ID_W-1:0]     win_id;

    // Fixed priority: scan downward so the lowest enabled index wins.
    always_comb begin
        active = pending_q & mask_q;
        win_id = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Next-state, pending bookkeeping and registered output decode.
    always_comb begin
        state_d     = state_q;
        irq_id_d    = irq_id_q;
        pending_clr = '0;

        case (state_q)
            ST_IDLE: begin
                if ((|active) && !CPSR_7) begin
                    state_d  = ST_REQ;
                    irq_id_d = win_id;
                end
            end
            ST_REQ: begin
                if (INTA_irq) begin
                    pending_clr = N_SRC'(1) << irq_id_q;
                    state_d     = ST_SERVICE;
                end else if (CPSR_7) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (IRQ_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rise         = EX_irq & ~prev_q;
        prev_d       = EX_irq;
        // A new edge in the acknowledge cycle must survive the clear.
        pending_d    = (pending_q & ~pending_clr) | rise;
        mask_d       = mask_we ? mask_wdata : mask_q;
        int_irq_d    = (state_d == ST_REQ);
        in_service_d = (state_d == ST_SERVICE);
    end

    // State and data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            irq_id_q     <= '0;
            int_irq_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            irq_id_q     <= irq_id_d;
            int_irq_q    <= int_irq_d;
            in_service_q <= in_service_d;
        end
    end

    assign INT_irq    = int_irq_q;
    assign in_service = in_service_q;
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign irq_vector = VEC_BASE + (32'(irq_id_q) << 2);

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed stimulus with hand-computed expectations.
// Each expected request (id, vector) is queued when its source is stimulated;
// a monitor pops and checks it whenever INT_irq rises.
module tb_irq_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ex_irq;
    logic        cpsr_7;
    logic        inta_irq;
    logic        irq_done;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        int_irq;
    logic [2:0]  irq_id;
    logic [31:0] irq_vector;
    logic        in_service;
    logic [7:0]  pending;
    logic [7:0]  mask;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] vec;
    } exp_req_t;

    exp_req_t exp_q[$];
    int total = 0;
    int bad   = 0;
    logic int_prev = 1'b0;

    irq_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .EX_irq     (ex_irq),
        .CPSR_7     (cpsr_7),
        .INTA_irq   (inta_irq),
        .IRQ_done   (irq_done),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .INT_irq    (int_irq),
        .irq_id     (irq_id),
        .irq_vector (irq_vector),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack();
        inta_irq = 1'b1;
        tick();
        inta_irq = 1'b0;
    endtask

    task automatic done_pulse();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
    endtask

    task automatic push_req(input logic [2:0] id, input logic [31:0] vec);
        exp_req_t e;
        e.id  = id;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    // Scoreboard monitor: every new request must match the oldest expectation.
    always @(negedge clk) begin
        if (int_irq && !int_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got id=%0d vector=0x%0h expected none at %0t",
                         irq_id, irq_vector, $time);
            end else begin
                exp_req_t e;
                e = exp_q.pop_front();
                total++;
                if (irq_id !== e.id) begin
                    bad++;
                    $display("FAIL req_id: got=%0d expected=%0d at %0t", irq_id, e.id, $time);
                end
                total++;
                if (irq_vector !== e.vec) begin
                    bad++;
                    $display("FAIL req_vector: got=0x%0h expected=0x%0h at %0t",
                             irq_vector, e.vec, $time);
                end
            end
        end
        int_prev = int_irq;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        ex_irq     = 8'h00;
        cpsr_7     = 1'b0;
        inta_irq   = 1'b0;
        irq_done   = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_int",     32'(int_irq), 32'h0);
        check("rst_insvc",   32'(in_service), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_mask",    32'(mask), 32'h0);
        check("rst_id",      32'(irq_id), 32'h0);
        check("rst_vector",  irq_vector, 32'h18);
        rst_n = 1'b1;
        tick();

        // Basic single-source handshake, source 3
        write_mask(8'hFF);
        check("t1_mask", 32'(mask), 32'hFF);
        ex_irq = 8'h08;
        push_req(3'd3, 32'h24);
        tick();
        check("t1_pend", 32'(pending), 32'h08);
        check("t1_int_early", 32'(int_irq), 32'h0);
        tick();
        check("t1_int", 32'(int_irq), 32'h1);
        check("t1_id", 32'(irq_id), 32'h3);
        check("t1_vec", irq_vector, 32'h24);
        tick();
        check("t1_int_hold", 32'(int_irq), 32'h1);
        ack();
        check("t1_pend_clr", 32'(pending), 32'h00);
        check("t1_insvc", 32'(in_service), 32'h1);
        check("t1_int_drop", 32'(int_irq), 32'h0);
        tick();
        tick();
        done_pulse();
        check("t1_idle_insvc", 32'(in_service), 32'h0);
        check("t1_idle_int", 32'(int_irq), 32'h0);
        ex_irq = 8'h00;
        tick();

        // Simultaneous sources 5 and 2: 2 first, then 5
        ex_irq = 8'h24;
        push_req(3'd2, 32'h20);
        push_req(3'd5, 32'h2C);
        tick();
        check("t2_pend", 32'(pending), 32'h24);
        tick();
        check("t2_int", 32'(int_irq), 32'h1);
        check("t2_id", 32'(irq_id), 32'h2);
        ack();
        check("t2_pend_after", 32'(pending), 32'h20);
        check("t2_id_frozen", 32'(irq_id), 32'h2);
        tick();
        done_pulse();
        check("t2_idle_int", 32'(int_irq), 32'h0);
        check("t2_idle_insvc", 32'(in_service), 32'h0);
        tick();
        check("t2_int5", 32'(int_irq), 32'h1);
        check("t2_id5", 32'(irq_id), 32'h5);
        check("t2_vec5", irq_vector, 32'h2C);
        ack();
        done_pulse();
        ex_irq = 8'h00;
        tick();

        // CPSR I-bit gating and withdrawal
        cpsr_7 = 1'b1;
        ex_irq = 8'h01;
        tick();
        tick();
        tick();
        check("t3_blocked_int", 32'(int_irq), 32'h0);
        check("t3_blocked_pend", 32'(pending), 32'h01);
        push_req(3'd0, 32'h18);
        cpsr_7 = 1'b0;
        tick();
        check("t3_int_k1", 32'(int_irq), 32'h1);
        check("t3_id", 32'(irq_id), 32'h0);
        cpsr_7 = 1'b1;
        tick();
        check("t3_withdraw_int", 32'(int_irq), 32'h0);
        check("t3_withdraw_pend", 32'(pending), 32'h01);
        push_req(3'd0, 32'h18);
        cpsr_7 = 1'b0;
        tick();
        check("t3_reraise", 32'(int_irq), 32'h1);
        ack();
        done_pulse();
        check("t3_pend_final", 32'(pending), 32'h00);
        ex_irq = 8'h00;
        tick();

        // Masked source latches but is not requested until unmasked
        write_mask(8'h00);
        ex_irq = 8'h02;
        tick();
        check("t4_pend", 32'(pending), 32'h02);
        tick();
        tick();
        check("t4_masked_int", 32'(int_irq), 32'h0);
        push_req(3'd1, 32'h1C);
        mask_we    = 1'b1;
        mask_wdata = 8'h02;
        tick();
        mask_we    = 1'b0;
        check("t4_mask", 32'(mask), 32'h02);
        check("t4_int_w1", 32'(int_irq), 32'h0);
        tick();
        check("t4_int_w2", 32'(int_irq), 32'h1);
        check("t4_id", 32'(irq_id), 32'h1);
        write_mask(8'h00);
        check("t4_mask_no_withdraw", 32'(int_irq), 32'h1);
        ack();
        done_pulse();
        write_mask(8'hFF);
        ex_irq = 8'h00;
        tick();

        // Re-edge in the acknowledge cycle: set wins over clear
        ex_irq = 8'h10;
        push_req(3'd4, 32'h28);
        push_req(3'd4, 32'h28);
        tick();
        tick();
        check("t5_int", 32'(int_irq), 32'h1);
        check("t5_id", 32'(irq_id), 32'h4);
        ex_irq = 8'h00;
        tick();
        ex_irq = 8'h10;
        ack();
        check("t5_pend_kept", 32'(pending), 32'h10);
        check("t5_insvc", 32'(in_service), 32'h1);
        done_pulse();
        check("t5_idle_int", 32'(int_irq), 32'h0);
        tick();
        check("t5_again_int", 32'(int_irq), 32'h1);
        check("t5_again_id", 32'(irq_id), 32'h4);
        ack();
        done_pulse();
        check("t5_pend_final", 32'(pending), 32'h00);
        ex_irq = 8'h00;
        tick();

        // Reset in SERVICE with pending 0x81, then stale pulses
        ex_irq = 8'h81;
        push_req(3'd0, 32'h18);
        tick();
        tick();
        check("t6_id", 32'(irq_id), 32'h0);
        ack();
        check("t6_pend80", 32'(pending), 32'h80);
        ex_irq = 8'h80;
        tick();
        ex_irq = 8'h81;
        tick();
        check("t6_pend81", 32'(pending), 32'h81);
        check("t6_insvc", 32'(in_service), 32'h1);
        rst_n  = 1'b0;
        ex_irq = 8'h00;
        tick();
        check("t6_rst_int", 32'(int_irq), 32'h0);
        check("t6_rst_insvc", 32'(in_service), 32'h0);
        check("t6_rst_pend", 32'(pending), 32'h00);
        check("t6_rst_mask", 32'(mask), 32'h00);
        check("t6_rst_id", 32'(irq_id), 32'h0);
        check("t6_rst_vec", irq_vector, 32'h18);
        rst_n    = 1'b1;
        inta_irq = 1'b1;
        irq_done = 1'b1;
        tick();
        inta_irq = 1'b0;
        irq_done = 1'b0;
        check("t6_stale_int", 32'(int_irq), 32'h0);
        check("t6_stale_insvc", 32'(in_service), 32'h0);
        check("t6_stale_pend", 32'(pending), 32'h00);
        write_mask(8'hFF);
        tick();
        tick();
        check("t6_idle_int", 32'(int_irq), 32'h0);

        tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Multi-source IRQ controller that sequences interrupt entry for the ARM core. It edge-detects and latches up to N_SRC external requests, applies a software mask and the CPSR I-bit, and selects one source by fixed priority. It then runs the INT_irq/INTA_irq handshake with the decode stage and supplies the handler vector. It holds off further requests until the handler signals return, so interrupts are never nested.

## Interface
- N_SRC, 8, number of external IRQ sources (2..32)
- VEC_BASE, 32'h0000_0018, vector address of source 0; source i vectors to VEC_BASE + 4*i
- ID_W, $clog2(N_SRC), width of irq_id (derived, not overridden)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- EX_irq  in  N_SRC  external requests, synchronous to clk, level signals whose rising edge raises a request
- CPSR_7  in  1  CPSR I-bit; 1 = IRQ disabled
- INTA_irq  in  1  one-cycle acknowledge from decode
- IRQ_done  in  1  one-cycle pulse at handler return
- mask_we  in  1  mask write strobe
- mask_wdata  in  N_SRC  new mask; bit=1 enables the source
- INT_irq  out  1  interrupt request to decode (registered)
- irq_id  out  ID_W  source being requested or serviced
- irq_vector  out  32  VEC_BASE + {irq_id,2'b00}, modulo 2^32
- in_service  out  1  handler active
- pending  out  N_SRC  latched request bits
- mask  out  N_SRC  current mask

## Operation
- Per source: prev[i] <= EX_irq[i]. Edge when EX_irq[i] & ~prev[i], which sets pending[i].
- Masked sources still latch pending. They are not requested until unmasked.
- Priority: lowest index among (pending & mask) wins; fixed, no round-robin.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if |(pending & mask) and CPSR_7==0, go to REQ and latch the winner into irq_id. Otherwise stay in IDLE.
  - REQ: INT_irq=1. If INTA_irq==1, clear pending[irq_id] and go to SERVICE. Else if CPSR_7==1, withdraw and go to IDLE; pending is unchanged. Else stay in REQ.
  - SERVICE: in_service=1 and INT_irq=0. When IRQ_done==1, go to IDLE.
- irq_id is frozen from IDLE->REQ until the next IDLE->REQ. A higher-priority arrival during REQ or SERVICE does not preempt.
- Set and clear of the same pending bit in the same cycle: set wins, so the bit stays 1.
- INTA_irq outside REQ and IRQ_done outside SERVICE are ignored.
- mask_we: mask <= mask_wdata at the clock edge. A mask change during REQ does not withdraw the request.
- Reset (rst_n==0 at a clock edge): state=IDLE, pending=0, prev=0, mask=0 (all disabled), irq_id=0, INT_irq=0, in_service=0, irq_vector=VEC_BASE. Reset overrides every other input, including mid-REQ and mid-SERVICE.

## Timing
- Edge sampled at cycle t: pending[i]=1 from t+1. State=REQ and INT_irq=1 from t+2, when the controller is IDLE, the source is enabled, and CPSR_7=0.
- INTA_irq at cycle a (in REQ): from a+1, INT_irq=0, in_service=1, and pending[id]=0 (unless a new edge occurred in cycle a).
- IRQ_done at cycle d: from d+1, in IDLE. If further work is pending and CPSR_7=0 at d+1, REQ is reached at d+2.
- CPSR_7 rising in REQ at cycle c: INT_irq=0 from c+1.
- irq_vector is combinational from registered irq_id, so it is valid in the same cycle as INT_irq.
- All outputs are registered or derived from registers. No input-to-output combinational path.

## Test plan
- Reset, mask=8'hFF, CPSR_7=0, EX_irq[3] rises at cycle 10 -> pending=8'h08 at 11; INT_irq=1, irq_id=3, irq_vector=32'h24 at 12; INTA at 14 -> pending=0, in_service=1 at 15; IRQ_done at 20 -> IDLE at 21.
- EX_irq[5] and EX_irq[2] rise in the same cycle -> irq_id=2 is serviced first. After IRQ_done, irq_id=5 is requested 2 cycles later with irq_vector=32'h2C.
- CPSR_7=1 while pending[0]=1 -> INT_irq stays 0. CPSR_7 falls at cycle k -> INT_irq=1 at k+1. CPSR_7 rises while in REQ -> INT_irq=0 next cycle and pending[0] is still 1.
- mask=8'h00, EX_irq[1] rises -> pending=8'h02 and no INT_irq. Writing mask=8'h02 -> INT_irq=1 two cycles after the write.
- EX_irq[4] re-rises in the same cycle as INTA for id 4 -> pending[4] stays 1. After IRQ_done, source 4 is requested again.
- rst_n=0 during SERVICE with pending=8'h81 -> the next cycle shows all outputs at reset values and pending=0. Stale INTA_irq and IRQ_done pulses have no effect.
